// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew data-hazard stalls plus mult/div busy interlock.
// Stall outputs are combinational with zero latency; asserting stall is the hold, with no other backpressure.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs_D,
  input  logic [4:0]  Rt_D,
  input  logic [1:0]  Tuse_rs_D,
  input  logic [1:0]  Tuse_rt_D,
  input  logic [4:0]  A3_E,
  input  logic [1:0]  Tnew_E,
  input  logic [4:0]  A3_M,
  input  logic [1:0]  Tnew_M,
  input  logic        md_D,
  input  logic        start_E,
  input  logic        div_E,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Flush_E,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic [3:0] md_cnt;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;
  logic       md_busy_raw;
  logic       stall;

  // $0 never hazards; Tuse=3 never stalls because Tnew cannot exceed 2.
  assign stall_rs = (Rs_D != 5'd0) &
                    (((A3_E == Rs_D) & (Tnew_E > Tuse_rs_D)) |
                     ((A3_M == Rs_D) & (Tnew_M > Tuse_rs_D)));
  assign stall_rt = (Rt_D != 5'd0) &
                    (((A3_E == Rt_D) & (Tnew_E > Tuse_rt_D)) |
                     ((A3_M == Rt_D) & (Tnew_M > Tuse_rt_D)));

  assign md_busy_raw = start_E | (md_cnt != 4'd0);
  assign stall_md    = md_D & md_busy_raw;

  // Reset masks every output combinationally, independent of the other inputs.
  assign stall   = ~reset & (stall_rs | stall_rt | stall_md);
  assign md_busy = ~reset & md_busy_raw;
  assign Stall_F = stall;
  assign Stall_D = stall;
  assign Flush_E = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (start_E) begin
      md_cnt <= div_E ? 4'd10 : 4'd5;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expected responses queued by stimulus, checked by a monitor.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs_D, Rt_D, A3_E, A3_M;
  logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
  logic        md_D, start_E, div_E;
  logic        Stall_F, Stall_D, Flush_E, md_busy;
  logic [31:0] stall_cnt;

  typedef struct {
    string       nm;
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
    .A3_E(A3_E), .Tnew_E(Tnew_E), .A3_M(A3_M), .Tnew_M(Tnew_M),
    .md_D(md_D), .start_E(start_E), .div_E(div_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_E(Flush_E),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  task automatic idle();
    reset = 1'b0; Rs_D = 5'd0; Rt_D = 5'd0; Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3;
    A3_E = 5'd0; Tnew_E = 2'd0; A3_M = 5'd0; Tnew_M = 2'd0;
    md_D = 1'b0; start_E = 1'b0; div_E = 1'b0;
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input string nm, input logic es, input logic eb, input logic [31:0] ec);
    exp_t e;
    e.nm = nm; e.stall = es; e.busy = eb; e.cnt = ec;
    exp_q.push_back(e);
  endtask

  // Monitor: one response per cycle, sampled mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (Stall_F !== e.stall || Stall_D !== e.stall || Flush_E !== e.stall ||
            md_busy !== e.busy || stall_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL %s: got F/D/E=%b%b%b busy=%b cnt=%0d, want stall=%b busy=%b cnt=%0d",
                   e.nm, Stall_F, Stall_D, Flush_E, md_busy, stall_cnt, e.stall, e.busy, e.cnt);
        end
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;

    // Reset masks outputs even with hazard and mult/div inputs active.
    nxt(); reset = 1; Rs_D = 5; Tuse_rs_D = 1; A3_E = 5; Tnew_E = 2; md_D = 1; start_E = 1;
    chk("rst_force", 0, 0, 0);
    nxt(); reset = 1; chk("rst_idle", 0, 0, 0);

    // Load-use
    nxt(); Rs_D = 5; Tuse_rs_D = 1; A3_E = 5; Tnew_E = 2; chk("load_use_E", 1, 0, 0);
    nxt(); Rs_D = 5; Tuse_rs_D = 1; A3_M = 5; Tnew_M = 1; chk("load_use_M", 0, 0, 1);

    // Branch after ALU
    nxt(); Rt_D = 8; Tuse_rt_D = 0; A3_E = 8; Tnew_E = 1; chk("br_alu_E", 1, 0, 1);
    nxt(); Rt_D = 8; Tuse_rt_D = 0; A3_M = 8; Tnew_M = 0; chk("br_alu_M", 0, 0, 2);

    // $0 and unused operand
    nxt(); Rs_D = 0; Tuse_rs_D = 0; A3_E = 0; Tnew_E = 2; chk("reg_zero", 0, 0, 2);
    nxt(); Rt_D = 9; Tuse_rt_D = 3; A3_E = 9; Tnew_E = 2; chk("tuse_unused", 0, 0, 2);
    nxt(); Rt_D = 3; Tuse_rt_D = 0; A3_M = 3; Tnew_M = 1; chk("rt_load_M", 1, 0, 2);
    nxt(); Rs_D = 4; Tuse_rs_D = 0; A3_E = 6; Tnew_E = 2; chk("reg_differ", 0, 0, 3);

    // Clear the counter, then divide with md_D held.
    nxt(); reset = 1; chk("rst_clear", 0, 0, 3);
    nxt(); chk("post_rst", 0, 0, 0);
    nxt(); md_D = 1; start_E = 1; div_E = 1; chk("div_start", 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      nxt(); md_D = 1; chk($sformatf("div_cnt%0d", 10 - i), 1, 1, 32'(1 + i));
    end
    nxt(); md_D = 1; chk("div_done", 0, 0, 11);

    // Multiply without md_D: busy for 6 cycles, never stalls.
    nxt(); start_E = 1; chk("mul_start", 0, 1, 11);
    for (int i = 0; i < 5; i++) begin
      nxt(); chk($sformatf("mul_cnt%0d", 5 - i), 0, 1, 11);
    end
    nxt(); chk("mul_done", 0, 0, 11);

    // Divide start while multiply in flight reloads to 10.
    nxt(); start_E = 1; chk("reload_mul", 0, 1, 11);
    nxt(); start_E = 1; div_E = 1; chk("reload_div", 0, 1, 11);
    for (int i = 0; i < 10; i++) begin
      nxt(); chk($sformatf("reload_cnt%0d", 10 - i), 0, 1, 11);
    end
    nxt(); chk("reload_done", 0, 0, 11);

    // Reset mid-divide at md_cnt=4.
    nxt(); start_E = 1; div_E = 1; chk("mid_div_start", 0, 1, 11);
    for (int i = 0; i < 6; i++) begin
      nxt(); chk($sformatf("mid_div_cnt%0d", 10 - i), 0, 1, 11);
    end
    nxt(); reset = 1; md_D = 1; Rs_D = 5; Tuse_rs_D = 0; A3_E = 5; Tnew_E = 2;
    chk("mid_div_rst", 0, 0, 11);
    nxt(); md_D = 1; chk("after_rst_md", 0, 0, 0);

    // Data hazard and md stall together count once.
    nxt(); md_D = 1; start_E = 1; Rs_D = 5; Tuse_rs_D = 1; A3_E = 5; Tnew_E = 2;
    chk("multi_cause", 1, 1, 0);
    nxt(); chk("multi_once", 0, 1, 1);

    nxt();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
